// File: rtl/store_unit_if.sv
// store_unit_if: store request, memory/IO write ports and hazard/status signals of the store unit.
// slave  : store_unit view (consumes st_*, io_ready, ld_addr; drives write ports and status).
// master : pipeline/memory-side view (the opposite directions).
interface store_unit_if #(parameter int MEM_AW = 14);
  logic              st_valid;
  logic              st_ready;
  logic [2:0]        st_funct3;
  logic              st_fp;
  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic              imem_wr_allow;
  logic [3:0]        dmem_we;
  logic [MEM_AW-1:0] dmem_addr;
  logic [31:0]       dmem_din;
  logic [3:0]        imem_we;
  logic [MEM_AW-1:0] imem_addr;
  logic [31:0]       imem_din;
  logic              io_valid;
  logic              io_ready;
  logic [31:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [3:0]        io_we;
  logic [31:0]       ld_addr;
  logic              ld_hazard;
  logic              empty;
  logic              misalign_err;
  modport slave (
    input  st_valid, st_funct3, st_fp, st_addr, st_data, imem_wr_allow, io_ready, ld_addr,
    output st_ready, dmem_we, dmem_addr, dmem_din, imem_we, imem_addr, imem_din,
           io_valid, io_addr, io_wdata, io_we, ld_hazard, empty, misalign_err
  );
  modport master (
    output st_valid, st_funct3, st_fp, st_addr, st_data, imem_wr_allow, io_ready, ld_addr,
    input  st_ready, dmem_we, dmem_addr, dmem_din, imem_we, imem_addr, imem_din,
           io_valid, io_addr, io_wdata, io_we, ld_hazard, empty, misalign_err
  );
endinterface

// File: rtl/store_unit.sv
// store_unit: aligns SB/SH/SW/FSW requests, buffers them in order and drains to DMEM, IMEM or IO.
// clk : rising-edge clock
// rst : asynchronous active-low reset
// bus : store_unit_if.slave carrying the store request, DMEM/IMEM/IO write ports,
//       load hazard query, empty flag and misalign_err pulse
module store_unit #(
  parameter int DEPTH  = 2,
  parameter int MEM_AW = 14
) (
  input logic        clk,
  input logic        rst,
  store_unit_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [PW-1:0] rd, wr, off;
  logic [PW:0]   cnt;
  logic [31:0]   a_q [DEPTH];
  logic [31:0]   d_q [DEPTH];
  logic [3:0]    w_q [DEPTH];
  logic [2:0]    t_q [DEPTH];
  logic          wd, hf, bt, bad, dm, im, io, acc, push, pop, hv, hz;
  logic [3:0]    we, rg;
  logic [31:0]   dat;
  always_comb begin
    wd   = bus.st_fp || bus.st_funct3 == 3'b010;
    hf   = !bus.st_fp && bus.st_funct3 == 3'b001;
    bt   = !bus.st_fp && bus.st_funct3 == 3'b000;
    bad  = !(wd || hf || bt) || (hf && bus.st_addr[0]) || (wd && bus.st_addr[1:0] != 2'b00);
    we   = wd ? 4'hf : hf ? (bus.st_addr[1] ? 4'hc : 4'h3) : 4'b0001 << bus.st_addr[1:0];
    dat  = wd ? bus.st_data : hf ? {2{bus.st_data[15:0]}} : {4{bus.st_data[7:0]}};
    rg   = bus.st_addr[31:28];
    dm   = rg == 4'h1 || rg == 4'h3;
    im   = (rg == 4'h2 || rg == 4'h3) && bus.imem_wr_allow;
    io   = rg == 4'h8;
    acc  = bus.st_valid && bus.st_ready;
    // silently-dropped targets handshake but never take an entry
    push = acc && !bad && (dm || im || io);
    hv   = cnt != '0;
    pop  = hv && (t_q[rd][2] ? bus.io_ready : 1'b1);
  end
  always_comb begin
    hz  = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // entry i is live when its distance from the read pointer is below the count
      off = PW'(i) - rd;
      if ({1'b0, off} < cnt && a_q[i][31:2] == bus.ld_addr[31:2]) hz = 1'b1;
    end
  end
  assign bus.st_ready  = cnt < (PW+1)'(DEPTH);
  assign bus.empty     = !hv;
  assign bus.ld_hazard = hz;
  assign bus.dmem_we   = (hv && t_q[rd][0]) ? w_q[rd] : 4'h0;
  assign bus.imem_we   = (hv && t_q[rd][1]) ? w_q[rd] : 4'h0;
  assign bus.dmem_addr = a_q[rd][MEM_AW+1:2];
  assign bus.imem_addr = a_q[rd][MEM_AW+1:2];
  assign bus.dmem_din  = d_q[rd];
  assign bus.imem_din  = d_q[rd];
  assign bus.io_valid  = hv && t_q[rd][2];
  assign bus.io_addr   = a_q[rd];
  assign bus.io_wdata  = d_q[rd];
  assign bus.io_we     = bus.io_valid ? w_q[rd] : 4'h0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd               <= '0;
      wr               <= '0;
      cnt              <= '0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.misalign_err <= acc && bad;
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      a_q[wr] <= bus.st_addr;
      d_q[wr] <= dat;
      w_q[wr] <= we;
      t_q[wr] <= {io, im, dm};
    end
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: scoreboard-driven checks of alignment, target decode, drops, IO stall, hazard and reset.
module tb_store_unit;
  typedef struct {
    logic [1:0]  k;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;
  logic clk = 0;
  logic rst = 0;
  int total = 0;
  int bad = 0;
  ev_t sb[$];
  store_unit_if #(.MEM_AW(14)) bus();
  store_unit #(.DEPTH(2), .MEM_AW(14)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic expect_ev(input logic [1:0] k, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.k = k; e.we = we; e.a = a; e.d = d;
    sb.push_back(e);
  endtask
  task automatic chk_ev(input logic [1:0] k, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_write k=%0d we=%b a=%h d=%h", k, we, a, d);
    end else begin
      e = sb.pop_front();
      if (e.k !== k || e.we !== we || e.a !== a || e.d !== d) begin
        bad++;
        $display("FAIL write_event got k=%0d we=%b a=%h d=%h want k=%0d we=%b a=%h d=%h",
                 k, we, a, d, e.k, e.we, e.a, e.d);
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dmem_we != 4'h0) chk_ev(2'd0, bus.dmem_we, 32'(bus.dmem_addr), bus.dmem_din);
      if (bus.imem_we != 4'h0) chk_ev(2'd1, bus.imem_we, 32'(bus.imem_addr), bus.imem_din);
      if (bus.io_valid && bus.io_ready) chk_ev(2'd2, bus.io_we, bus.io_addr, bus.io_wdata);
    end
  end
  task automatic store(input logic [2:0] f3, input logic fp, input logic [31:0] a, input logic [31:0] d);
    int n;
    bus.st_valid = 1; bus.st_funct3 = f3; bus.st_fp = fp; bus.st_addr = a; bus.st_data = d;
    n = 0;
    while (!bus.st_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL st_ready_timeout got=0 want=1");
    end
    @(posedge clk); #1;
    bus.st_valid = 0;
  endtask
  task automatic test_reset;
    #1;
    total += 8;
    if (bus.dmem_we !== 4'h0)    begin bad++; $display("FAIL rst_dmem_we got=%b want=0000", bus.dmem_we); end
    if (bus.imem_we !== 4'h0)    begin bad++; $display("FAIL rst_imem_we got=%b want=0000", bus.imem_we); end
    if (bus.io_we !== 4'h0)      begin bad++; $display("FAIL rst_io_we got=%b want=0000", bus.io_we); end
    if (bus.io_valid !== 1'b0)   begin bad++; $display("FAIL rst_io_valid got=%b want=0", bus.io_valid); end
    if (bus.empty !== 1'b1)      begin bad++; $display("FAIL rst_empty got=%b want=1", bus.empty); end
    if (bus.misalign_err !== 0)  begin bad++; $display("FAIL rst_misalign got=%b want=0", bus.misalign_err); end
    if (bus.st_ready !== 1'b1)   begin bad++; $display("FAIL rst_st_ready got=%b want=1", bus.st_ready); end
    if (bus.ld_hazard !== 1'b0)  begin bad++; $display("FAIL rst_ld_hazard got=%b want=0", bus.ld_hazard); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_byte;
    expect_ev(2'd0, 4'b1000, 32'h0, 32'hDDDD_DDDD);
    store(3'b000, 0, 32'h1000_0003, 32'hAABB_CCDD);
    total += 5;
    if (bus.dmem_we !== 4'b1000)        begin bad++; $display("FAIL sb_we got=%b want=1000", bus.dmem_we); end
    if (bus.dmem_din !== 32'hDDDD_DDDD) begin bad++; $display("FAIL sb_din got=%h want=dddddddd", bus.dmem_din); end
    if (bus.dmem_addr !== 14'h0)        begin bad++; $display("FAIL sb_addr got=%h want=0000", bus.dmem_addr); end
    if (bus.empty !== 1'b0)             begin bad++; $display("FAIL sb_not_empty got=%b want=0", bus.empty); end
    @(posedge clk); #1;
    if (bus.empty !== 1'b1)             begin bad++; $display("FAIL sb_empty_after got=%b want=1", bus.empty); end
  endtask
  task automatic test_half;
    bus.imem_wr_allow = 1;
    expect_ev(2'd0, 4'b1100, 32'h1, 32'h5678_5678);
    expect_ev(2'd1, 4'b1100, 32'h1, 32'h5678_5678);
    store(3'b001, 0, 32'h3000_0006, 32'h1234_5678);
    total += 3;
    if (bus.dmem_we !== 4'b1100)        begin bad++; $display("FAIL sh_dmem_we got=%b want=1100", bus.dmem_we); end
    if (bus.imem_we !== 4'b1100)        begin bad++; $display("FAIL sh_imem_we got=%b want=1100", bus.imem_we); end
    if (bus.imem_din !== 32'h5678_5678) begin bad++; $display("FAIL sh_imem_din got=%h want=56785678", bus.imem_din); end
    @(posedge clk); #1;
    bus.imem_wr_allow = 0;
    expect_ev(2'd0, 4'b1100, 32'h1, 32'h5678_5678);
    store(3'b001, 0, 32'h3000_0006, 32'h1234_5678);
    total += 2;
    if (bus.dmem_we !== 4'b1100) begin bad++; $display("FAIL sh2_dmem_we got=%b want=1100", bus.dmem_we); end
    if (bus.imem_we !== 4'b0000) begin bad++; $display("FAIL sh2_imem_we got=%b want=0000", bus.imem_we); end
    @(posedge clk); #1;
    expect_ev(2'd0, 4'b0011, 32'h2, 32'h5678_5678);
    store(3'b001, 0, 32'h1000_0008, 32'h1234_5678);
    @(posedge clk); #1;
    expect_ev(2'd0, 4'b1111, 32'h3, 32'h0BAD_BEEF);
    store(3'b011, 1, 32'h1000_000C, 32'h0BAD_BEEF);
    @(posedge clk); #1;
  endtask
  task automatic test_io_stall_hazard;
    bus.io_ready = 0;
    expect_ev(2'd2, 4'hf, 32'h8000_0008, 32'hCAFE_F00D);
    expect_ev(2'd0, 4'hf, 32'h4, 32'h1111_2222);
    expect_ev(2'd0, 4'hf, 32'h8, 32'h3333_4444);
    store(3'b010, 0, 32'h8000_0008, 32'hCAFE_F00D);
    store(3'b010, 0, 32'h1000_0010, 32'h1111_2222);
    total += 3;
    if (bus.st_ready !== 1'b0) begin bad++; $display("FAIL full_st_ready got=%b want=0", bus.st_ready); end
    bus.ld_addr = 32'h1000_0012; #1;
    if (bus.ld_hazard !== 1'b1) begin bad++; $display("FAIL hazard_hit got=%b want=1", bus.ld_hazard); end
    bus.ld_addr = 32'h1000_0014; #1;
    if (bus.ld_hazard !== 1'b0) begin bad++; $display("FAIL hazard_miss got=%b want=0", bus.ld_hazard); end
    bus.st_valid = 1; bus.st_funct3 = 3'b010; bus.st_fp = 0;
    bus.st_addr = 32'h1000_0020; bus.st_data = 32'h3333_4444;
    for (int i = 0; i < 3; i++) begin
      total += 4;
      if (bus.st_ready !== 1'b0)         begin bad++; $display("FAIL stall_st_ready c=%0d got=%b want=0", i, bus.st_ready); end
      if (bus.io_valid !== 1'b1)         begin bad++; $display("FAIL stall_io_valid c=%0d got=%b want=1", i, bus.io_valid); end
      if (bus.io_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_io_wdata c=%0d got=%h want=cafef00d", i, bus.io_wdata); end
      if (bus.dmem_we !== 4'h0)          begin bad++; $display("FAIL stall_dmem_we c=%0d got=%b want=0000", i, bus.dmem_we); end
      @(posedge clk); #1;
    end
    bus.io_ready = 1;
    @(posedge clk); #1;
    bus.io_ready = 0;
    total += 3;
    if (bus.io_valid !== 1'b0)  begin bad++; $display("FAIL io_popped got=%b want=0", bus.io_valid); end
    if (bus.st_ready !== 1'b1)  begin bad++; $display("FAIL after_pop_ready got=%b want=1", bus.st_ready); end
    if (bus.dmem_we !== 4'hf)   begin bad++; $display("FAIL after_pop_dmem_we got=%b want=1111", bus.dmem_we); end
    @(posedge clk); #1;
    bus.st_valid = 0;
    total += 1;
    if (bus.dmem_addr !== 14'h8) begin bad++; $display("FAIL third_addr got=%h want=0008", bus.dmem_addr); end
    @(posedge clk); #1;
    total += 1;
    if (bus.empty !== 1'b1) begin bad++; $display("FAIL drained_empty got=%b want=1", bus.empty); end
  endtask
  task automatic test_drops;
    store(3'b010, 0, 32'h1000_0002, 32'h1);
    total += 2;
    if (bus.misalign_err !== 1'b1) begin bad++; $display("FAIL mis_sw_err got=%b want=1", bus.misalign_err); end
    if (bus.empty !== 1'b1)        begin bad++; $display("FAIL mis_sw_empty got=%b want=1", bus.empty); end
    @(posedge clk); #1;
    total += 1;
    if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL mis_pulse_len got=%b want=0", bus.misalign_err); end
    store(3'b000, 0, 32'h4000_0000, 32'h1);
    total += 2;
    if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL bios_err got=%b want=0", bus.misalign_err); end
    if (bus.empty !== 1'b1)        begin bad++; $display("FAIL bios_empty got=%b want=1", bus.empty); end
    store(3'b001, 0, 32'h1000_0001, 32'h1);
    total += 1;
    if (bus.misalign_err !== 1'b1) begin bad++; $display("FAIL mis_sh_err got=%b want=1", bus.misalign_err); end
    store(3'b011, 0, 32'h1000_0000, 32'h1);
    total += 1;
    if (bus.misalign_err !== 1'b1) begin bad++; $display("FAIL funct3_err got=%b want=1", bus.misalign_err); end
    bus.imem_wr_allow = 0;
    store(3'b010, 0, 32'h2000_0000, 32'h1);
    total += 2;
    if (bus.misalign_err !== 1'b0) begin bad++; $display("FAIL imem_deny_err got=%b want=0", bus.misalign_err); end
    if (bus.empty !== 1'b1)        begin bad++; $display("FAIL imem_deny_empty got=%b want=1", bus.empty); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid;
    bus.io_ready = 0;
    store(3'b010, 0, 32'h8000_0000, 32'h5555_0000);
    store(3'b010, 0, 32'h8000_0004, 32'h5555_0001);
    total += 1;
    if (bus.io_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_io_valid got=%b want=1", bus.io_valid); end
    #2 rst = 0;
    #1;
    total += 3;
    if (bus.io_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_io_valid got=%b want=0", bus.io_valid); end
    if (bus.empty !== 1'b1)    begin bad++; $display("FAIL mid_rst_empty got=%b want=1", bus.empty); end
    if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", bus.st_ready); end
    @(negedge clk); rst = 1;
    bus.io_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.io_valid !== 1'b0 || bus.dmem_we !== 4'h0) begin
        bad++; $display("FAIL post_rst_write c=%0d io_valid=%b dmem_we=%b want 0/0000", i, bus.io_valid, bus.dmem_we);
      end
    end
  endtask
  initial begin
    bus.st_valid = 0; bus.st_funct3 = 0; bus.st_fp = 0; bus.st_addr = 0; bus.st_data = 0;
    bus.imem_wr_allow = 0; bus.io_ready = 0; bus.ld_addr = 0;
    test_reset;
    test_byte;
    test_half;
    test_io_stall_hazard;
    test_drops;
    test_reset_mid;
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL pending_expected got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Memory-write counterpart of the writeback/load path: accepts store requests (SB/SH/SW/FSW) from the execute stage.
- Generates per-byte write enables and lane-replicated write data.
- Buffers requests in a small in-order FIFO and drains them to DMEM, IMEM or the IO write interface.
- Flags load-after-store hazards so the pipeline can stall a load that targets a word still pending in the buffer.

Parameters:
- DEPTH, 2, number of store-buffer entries (power of two, >= 2).
- MEM_AW, 14, word-address width of the DMEM and IMEM write ports.

Ports:
- clk  input  1  single clock, all state rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- st_valid  input  1  store request present.
- st_ready  output  1  buffer can accept a request this cycle.
- st_funct3  input  3  store width: 000 byte, 001 half, 010 word.
- st_fp  input  1  request is FSW; treated as a word store.
- st_addr  input  32  byte address.
- st_data  input  32  unaligned source data (rs2 or frs2).
- imem_wr_allow  input  1  IMEM writes permitted; sampled at enqueue.
- dmem_we  output  4  DMEM byte write enables.
- dmem_addr  output  MEM_AW  DMEM word address (st_addr[MEM_AW+1:2]).
- dmem_din  output  32  DMEM write data.
- imem_we  output  4  IMEM byte write enables.
- imem_addr  output  MEM_AW  IMEM word address.
- imem_din  output  32  IMEM write data.
- io_valid  output  1  IO write request.
- io_ready  input  1  IO accepts the request.
- io_addr  output  32  IO byte address.
- io_wdata  output  32  IO write data.
- io_we  output  4  IO byte enables.
- ld_addr  input  32  address of the load currently in execute.
- ld_hazard  output  1  a pending entry matches ld_addr[31:2].
- empty  output  1  buffer holds no entries.
- misalign_err  output  1  one-cycle pulse when a request was dropped.

Behaviour:
- Reset (rst=0, async): buffer emptied, pointers and count cleared. Outputs go to: all *_we=0, io_valid=0, empty=1, misalign_err=0, st_ready=1, ld_hazard=0.
- Reset mid-transfer abandons the IO request without waiting for io_ready. Pending entries are lost.
- Alignment (computed at enqueue):
  - Byte store: we = 1 << addr[1:0]; data = {4{st_data[7:0]}}.
  - Half store: addr[1]=0 gives we=0011, addr[1]=1 gives we=1100; data = {2{st_data[15:0]}}. addr[0]=1 is misaligned.
  - Word store or st_fp=1: we=1111, data=st_data. addr[1:0]!=0 is misaligned.
  - funct3 values 011-111 with st_fp=0 are treated as unmapped.
- Target decode on addr[31:28]:
  - 0001 selects DMEM.
  - 0010 selects IMEM, only if imem_wr_allow=1.
  - 0011 selects DMEM, plus IMEM if imem_wr_allow=1.
  - 1000 selects IO.
  - Anything else (BIOS 0100, unmapped, or IMEM-only with imem_wr_allow=0) is dropped silently with no error.
- Drops:
  - Misaligned or unmapped-funct3 requests are dropped. misalign_err pulses high the cycle after acceptance (registered).
  - Dropped requests still handshake (st_ready honoured) and never occupy an entry.
- Handshake:
  - Transfer when st_valid && st_ready.
  - st_ready = (count < DEPTH), combinational from count only; there is no same-cycle pop bypass.
- Enqueue latency: a request accepted at edge N is visible at the head at cycle N+1. There is no empty-buffer bypass.
- Drain of the head entry (in order only):
  - Memory target: dmem_we/imem_we are driven from the head for exactly one cycle, and the entry pops at the end of that cycle.
  - IO target: io_valid=1 with io_addr, io_wdata and io_we held stable until io_ready=1. The entry pops on that edge. All *_we are 0 meanwhile.
  - Entries behind an IO head wait (no reordering).
- When no entry is draining to memory, all *_we are 0. dmem_din/imem_din are don't-care when the corresponding we=0.
- Simultaneous push and pop: count unchanged and pointers both advance. A push while count=DEPTH is impossible because st_ready=0.
- Pointer wrap modulo DEPTH.
- empty = (count==0).
- ld_hazard is combinational: OR over valid entries of (entry word address == ld_addr[31:2]). It is independent of ld_addr[1:0] and of target.

Test Plan:
- SB at 0x1000_0003 with data 0xAABB_CCDD -> next cycle dmem_we=1000, dmem_din=0xDDDD_DDDD, dmem_addr=0x000; empty returns to 1 the cycle after.
- SH at 0x3000_0006 with data 0x1234_5678 and imem_wr_allow=1 -> dmem_we=imem_we=1100, din=0x5678_5678, addr=0x001. Repeat with imem_wr_allow=0 -> imem_we stays 0000.
- SW at 0x8000_0008 with io_ready held 0 for 3 cycles -> io_valid stays high with io_wdata stable. A second SW pushes, a third sees st_ready=0 (DEPTH=2). The pop occurs on the io_ready edge.
- SW at 0x1000_0002 -> no entry queued, misalign_err high for exactly 1 cycle, empty stays 1. SB at 0x4000_0000 -> dropped, misalign_err stays 0.
- Pending SW at 0x1000_0010 blocked behind an IO head; ld_addr=0x1000_0012 -> ld_hazard=1. ld_addr=0x1000_0014 -> ld_hazard=0.
- Assert rst=0 asynchronously while io_valid=1 with 2 entries queued -> io_valid=0 immediately, empty=1, st_ready=1, and no later writes appear.
